lsu_mem_arbiter: RTL and testbench
==================================

# lsu_mem_arbiter

Sequencer for the single data-memory port in the out-of-order LSU. It shares the port between load-queue entries and committed stores from the store-queue head. Each load gets a memory request, and the block drives the `load_executed` and `load_succeeded` handshakes back into `load_queue`. Only one memory transaction is in flight at a time.

## Interface
- `XLEN`, 32, data/address width
- `ROB_TAG_WIDTH`, 32, ROB tag width
- `LDQ_SIZE`, 16, load-queue entries (power of two)
- `STARVE_LIMIT`, 4, consecutive load grants allowed while a store waits

Ports:
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `ldq_valid` in `LDQ_SIZE`: per-entry valid
- `ldq_address_valid` in `LDQ_SIZE`: per-entry address_valid
- `ldq_executed` in `LDQ_SIZE`: per-entry executed
- `ldq_address` in `LDQ_SIZE*XLEN`: entry i at bits `[i*XLEN +: XLEN]`
- `ldq_rob_tag` in `LDQ_SIZE*ROB_TAG_WIDTH`: entry i at bits `[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]`
- `ldq_head` in `$clog2(LDQ_SIZE)`: oldest LDQ entry index
- `stq_commit_valid` in 1: store at STQ head is committed and ready to write
- `stq_commit_addr` in `XLEN`: committed store address
- `stq_commit_data` in `XLEN`: committed store data
- `stq_commit_ack` out 1: one-cycle pulse when the store write completes
- `flush` in 1: pipeline flush; kills any in-flight load
- `mem_req_valid` out 1: request valid
- `mem_req_ready` in 1: memory accepts the request
- `mem_req_write` out 1: 1 = store, 0 = load
- `mem_req_addr` out `XLEN`: request address
- `mem_req_wdata` out `XLEN`: store data (0 for loads)
- `mem_resp_valid` in 1: response for the in-flight request
- `mem_resp_rdata` in `XLEN`: load data
- `load_executed` out 1: pulse when a load request is accepted
- `load_executed_rob_tag` out `ROB_TAG_WIDTH`: tag of that load
- `load_succeeded` out 1: pulse when load data returns
- `load_succeeded_rob_tag` out `ROB_TAG_WIDTH`: tag of that load
- `load_data` out `XLEN`: returned data, valid with `load_succeeded`

## Operation
**Eligible load**
- An entry is eligible when `valid & address_valid & ~executed`.
- Selection is the oldest eligible entry, scanning from `ldq_head` upward with wrap modulo `LDQ_SIZE`.

**FSM states: IDLE, REQ, RESP**
- IDLE, store waiting and `starve_cnt == STARVE_LIMIT`: grant the store.
- IDLE, store waiting and no eligible load: grant the store.
- IDLE, otherwise with an eligible load: grant the load.
- IDLE, nothing pending: stay in IDLE.
- On a grant, latch write, address, wdata and ROB tag into the request registers, then go to REQ.
- REQ: `mem_req_valid=1` with stable fields. On `mem_req_valid & mem_req_ready`, go to RESP.
- RESP: on `mem_resp_valid`, go to IDLE.

**Starvation counter (`starve_cnt`)**
- Increments on each load grant while `stq_commit_valid=1`.
- Saturates at `STARVE_LIMIT`.
- Clears on a store grant, and whenever `stq_commit_valid=0` in IDLE.

**Flush**
- A REQ already raised is held until accepted; the valid/ready rule is never broken.
- An in-flight load is marked killed. Its acceptance still pulses `load_executed`, but its response produces no `load_succeeded`.
- Stores are never killed, because committed stores are architectural.

**Completion**
- A load response registers `load_succeeded`, the latched tag and `mem_resp_rdata`.
- A store response pulses `stq_commit_ack`.

## Timing
**Reset values**
- All outputs 0, state IDLE, `starve_cnt` 0, kill flag 0.
- Reset mid-transaction abandons it; no pulses are generated.

**Latencies**
- Grant decision in cycle N gives `mem_req_valid=1` in cycle N+1.
- `load_executed` is combinational with the accepting handshake cycle: `mem_req_valid & mem_req_ready & ~mem_req_write`.
- `load_succeeded`, `load_data` and `stq_commit_ack` are registered: they assert in cycle R+1, where R is the `mem_resp_valid` cycle, and last 1 cycle.
- Back-to-back: a new grant is made in cycle R+1 (IDLE). The minimum period is 3 cycles per transaction with zero-wait memory.

**Boundary cases**
- The LDQ must see `executed` updated by the cycle after `load_executed`. The arbiter never re-grants the tag it currently holds in REQ or RESP.
- `mem_resp_valid` outside RESP is ignored.
- `flush` in the same cycle as the load's acceptance: the load is killed.
- `flush` in the same cycle as the load's response: `load_succeeded` is suppressed.
- Wrap: with `ldq_head=14`, eligible entries {1, 15} → grant 15.
- No eligible loads and no store: remain in IDLE, all pulses 0.

## Test plan
- Single load: entry 0 (tag 19, addr 42) eligible, ready=1, response at the next cycle with rdata 0xDEAD → `mem_req_addr=42`, `mem_req_write=0`, `load_executed` tag 19, then `load_succeeded` tag 19 with `load_data=0xDEAD` exactly one cycle after the response.
- Age order with wrap: `ldq_head=14`, entries 15 (tag 7) and 1 (tag 3) eligible → tag 7 issued first, tag 3 second.
- Starvation: `STARVE_LIMIT=4`, continuous eligible loads, `stq_commit_valid=1` (addr 0x100, data 5) → 4 load grants, then a store with `mem_req_write=1`, `wdata=5`, then `stq_commit_ack` pulse and counter cleared.
- Ready backpressure: `mem_req_ready=0` for 3 cycles → valid, addr and tag held constant; `load_executed` only in the accept cycle.
- Flush: assert `flush` while a load (tag 9) is in RESP → response consumed, no `load_succeeded`, FSM returns to IDLE and issues the next eligible load.
- Async reset while in REQ → all outputs 0 immediately, state IDLE, no pulses afterward.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
// Single data-memory port: request channel plus response channel.
interface lsu_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_write;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_rdata;

    // Arbiter side: issues requests, consumes responses.
    modport master (
        output mem_req_valid,
        output mem_req_write,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_rdata
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  mem_req_valid,
        input  mem_req_write,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_rdata
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Shares the single data-memory port between eligible load-queue entries and
// the committed store at the store-queue head. One transaction in flight.
module lsu_mem_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_TAG_WIDTH = 32,
    parameter int unsigned LDQ_SIZE      = 16,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [LDQ_SIZE-1:0]               ldq_valid,
    input  logic [LDQ_SIZE-1:0]               ldq_address_valid,
    input  logic [LDQ_SIZE-1:0]               ldq_executed,
    input  logic [LDQ_SIZE*XLEN-1:0]          ldq_address,
    input  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0] ldq_rob_tag,
    input  logic [$clog2(LDQ_SIZE)-1:0]       ldq_head,

    input  logic                              stq_commit_valid,
    input  logic [XLEN-1:0]                   stq_commit_addr,
    input  logic [XLEN-1:0]                   stq_commit_data,
    output logic                              stq_commit_ack,

    input  logic                              flush,

    lsu_mem_arbiter_if.master                 mem,

    output logic                              load_executed,
    output logic [ROB_TAG_WIDTH-1:0]          load_executed_rob_tag,
    output logic                              load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0]          load_succeeded_rob_tag,
    output logic [XLEN-1:0]                   load_data
);

    localparam int unsigned IDX_W = $clog2(LDQ_SIZE);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     req_valid_q, req_valid_d;
    logic                     req_write_q, req_write_d;
    logic [XLEN-1:0]          req_addr_q, req_addr_d;
    logic [XLEN-1:0]          req_wdata_q, req_wdata_d;
    logic [ROB_TAG_WIDTH-1:0] req_tag_q, req_tag_d;
    logic                     killed_q, killed_d;
    logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
    logic                     ack_q, ack_d;
    logic                     succ_q, succ_d;
    logic [ROB_TAG_WIDTH-1:0] succ_tag_q, succ_tag_d;
    logic [XLEN-1:0]          data_q, data_d;

    logic [LDQ_SIZE-1:0]      eligible;
    logic                     sel_found;
    logic [IDX_W-1:0]         sel_idx;
    logic [IDX_W-1:0]         cand;
    logic [XLEN-1:0]          sel_addr;
    logic [ROB_TAG_WIDTH-1:0] sel_tag;
    logic                     starve_full;
    logic                     pick_store;

    // Oldest eligible load: scan upward from the head, wrapping around the queue.
    always_comb begin
        eligible  = ldq_valid & ldq_address_valid & ~ldq_executed;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < LDQ_SIZE; i++) begin
            cand = ldq_head + IDX_W'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        sel_addr = ldq_address[sel_idx*XLEN +: XLEN];
        sel_tag  = ldq_rob_tag[sel_idx*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
    end

    // Store wins when loads have had their quota or there is no load to issue.
    assign starve_full = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    assign pick_store  = stq_commit_valid && (starve_full || !sel_found);

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_tag_d    = req_tag_q;
        killed_d     = killed_q;
        starve_cnt_d = starve_cnt_q;
        ack_d        = 1'b0;
        succ_d       = 1'b0;
        succ_tag_d   = '0;
        data_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_store) begin
                    state_d      = S_REQ;
                    req_valid_d  = 1'b1;
                    req_write_d  = 1'b1;
                    req_addr_d   = stq_commit_addr;
                    req_wdata_d  = stq_commit_data;
                    req_tag_d    = '0;
                    killed_d     = 1'b0;
                    starve_cnt_d = '0;
                end else if (sel_found) begin
                    state_d      = S_REQ;
                    req_valid_d  = 1'b1;
                    req_write_d  = 1'b0;
                    req_addr_d   = sel_addr;
                    req_wdata_d  = '0;
                    req_tag_d    = sel_tag;
                    // A flush in the grant cycle already dooms this load.
                    killed_d     = flush;
                    if (!stq_commit_valid) begin
                        starve_cnt_d = '0;
                    end else if (!starve_full) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else if (!stq_commit_valid) begin
                    starve_cnt_d = '0;
                end
            end

            S_REQ: begin
                // The raised request stays up until accepted, flush or not.
                if (flush && !req_write_q) begin
                    killed_d = 1'b1;
                end
                if (mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                if (flush && !req_write_q) begin
                    killed_d = 1'b1;
                end
                if (mem.mem_resp_valid) begin
                    state_d  = S_IDLE;
                    killed_d = 1'b0;
                    if (req_write_q) begin
                        ack_d = 1'b1;
                    end else if (!killed_q && !flush) begin
                        succ_d     = 1'b1;
                        succ_tag_d = req_tag_q;
                        data_d     = mem.mem_resp_rdata;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_valid_q  <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_tag_q    <= '0;
            killed_q     <= 1'b0;
            starve_cnt_q <= '0;
            ack_q        <= 1'b0;
            succ_q       <= 1'b0;
            succ_tag_q   <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_tag_q    <= req_tag_d;
            killed_q     <= killed_d;
            starve_cnt_q <= starve_cnt_d;
            ack_q        <= ack_d;
            succ_q       <= succ_d;
            succ_tag_q   <= succ_tag_d;
            data_q       <= data_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_write = req_write_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_wdata = req_wdata_q;

    // Load acceptance is reported in the handshake cycle itself.
    assign load_executed          = req_valid_q & mem.mem_req_ready & ~req_write_q;
    assign load_executed_rob_tag  = req_tag_q;
    assign load_succeeded         = succ_q;
    assign load_succeeded_rob_tag = succ_tag_q;
    assign load_data              = data_q;
    assign stq_commit_ack         = ack_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios, a bench-side memory and LDQ,
// and a transaction-level reference model checked every cycle.
module tb_lsu_mem_arbiter;

    localparam int NQ = 16;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NQ-1:0] ldq_valid, ldq_address_valid, ldq_executed;
    logic [31:0]   e_addr [NQ];
    logic [31:0]   e_tag  [NQ];
    logic [NQ*32-1:0] ldq_address, ldq_rob_tag;
    logic [3:0]    ldq_head;
    logic          stq_commit_valid;
    logic [31:0]   stq_commit_addr, stq_commit_data;
    logic          stq_commit_ack;
    logic          flush;
    logic          load_executed, load_succeeded;
    logic [31:0]   load_executed_rob_tag, load_succeeded_rob_tag, load_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            ldq_address[i*32 +: 32] = e_addr[i];
            ldq_rob_tag[i*32 +: 32] = e_tag[i];
        end
    end

    lsu_mem_arbiter_if #(.XLEN(32)) mem_if ();

    lsu_mem_arbiter #(.XLEN(32), .ROB_TAG_WIDTH(32), .LDQ_SIZE(NQ), .STARVE_LIMIT(SL)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ldq_valid              (ldq_valid),
        .ldq_address_valid      (ldq_address_valid),
        .ldq_executed           (ldq_executed),
        .ldq_address            (ldq_address),
        .ldq_rob_tag            (ldq_rob_tag),
        .ldq_head               (ldq_head),
        .stq_commit_valid       (stq_commit_valid),
        .stq_commit_addr        (stq_commit_addr),
        .stq_commit_data        (stq_commit_data),
        .stq_commit_ack         (stq_commit_ack),
        .flush                  (flush),
        .mem                    (mem_if),
        .load_executed          (load_executed),
        .load_executed_rob_tag  (load_executed_rob_tag),
        .load_succeeded         (load_succeeded),
        .load_succeeded_rob_tag (load_succeeded_rob_tag),
        .load_data              (load_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- bench memory ----------------
    int          rdy_delay  = 0;
    int          resp_delay = 0;
    int          wait_cnt   = 0;
    int          resp_cnt   = 0;
    bit          resp_pend  = 0;
    bit          stray      = 0;
    bit          m_hs       = 0;
    logic [31:0] m_hs_addr;
    logic [31:0] pend_addr;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        return (a == 32'd42) ? 32'h0000DEAD : (a ^ 32'hA5A50000);
    endfunction

    always @(negedge clk) begin
        m_hs      = mem_if.mem_req_valid && mem_if.mem_req_ready;
        m_hs_addr = mem_if.mem_req_addr;
    end

    always @(posedge clk) begin
        #1;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_rdata = '0;
        if (reset) begin
            resp_pend = 0;
            wait_cnt  = 0;
            mem_if.mem_req_ready = 1'b0;
        end else begin
            if (m_hs) begin
                resp_pend = 1;
                resp_cnt  = resp_delay;
                pend_addr = m_hs_addr;
                wait_cnt  = 0;
            end
            if (resp_pend) begin
                if (resp_cnt == 0) begin
                    mem_if.mem_resp_valid = 1'b1;
                    mem_if.mem_resp_rdata = rdata_for(pend_addr);
                    resp_pend = 0;
                end else begin
                    resp_cnt--;
                end
            end else if (stray) begin
                mem_if.mem_resp_valid = 1'b1;
                mem_if.mem_resp_rdata = 32'h00005151;
            end
            if (mem_if.mem_req_valid) begin
                mem_if.mem_req_ready = (wait_cnt >= rdy_delay);
                wait_cnt++;
            end else begin
                mem_if.mem_req_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    bit          t_act, t_acc, t_wr, t_kill;
    logic [31:0] t_addr, t_wdata, t_tag;
    int          t_idx;
    int          starve;
    bit          e_succ, e_ack;
    logic [31:0] e_stag, e_data;

    function automatic int oldest();
        for (int k = 0; k < NQ; k++) begin
            int i;
            i = (int'(ldq_head) + k) % NQ;
            if (ldq_valid[i] && ldq_address_valid[i] && !ldq_executed[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        bit exp_v, exp_exec, n_succ, n_ack;
        int idx;
        if (reset) begin
            t_act = 0; t_acc = 0; t_wr = 0; t_kill = 0; starve = 0;
            e_succ = 0; e_ack = 0;
            chk("rst_req_valid", mem_if.mem_req_valid, 0);
            chk("rst_req_addr", mem_if.mem_req_addr, 0);
            chk("rst_load_executed", load_executed, 0);
            chk("rst_load_succeeded", load_succeeded, 0);
            chk("rst_ack", stq_commit_ack, 0);
        end else begin
            exp_v    = t_act && !t_acc;
            exp_exec = exp_v && mem_if.mem_req_ready && !t_wr;
            chk("req_valid", mem_if.mem_req_valid, exp_v);
            if (exp_v) begin
                chk("req_write", mem_if.mem_req_write, t_wr);
                chk("req_addr", mem_if.mem_req_addr, t_addr);
                chk("req_wdata", mem_if.mem_req_wdata, t_wdata);
            end
            chk("load_executed", load_executed, exp_exec);
            if (exp_exec) chk("load_executed_tag", load_executed_rob_tag, t_tag);
            chk("load_succeeded", load_succeeded, e_succ);
            if (e_succ) begin
                chk("load_succeeded_tag", load_succeeded_rob_tag, e_stag);
                chk("load_data", load_data, e_data);
            end
            chk("stq_commit_ack", stq_commit_ack, e_ack);

            // the LDQ marks the entry executed once its request is accepted
            if (exp_exec) ldq_executed[t_idx] = 1'b1;

            n_succ = 0; n_ack = 0;
            if (t_act) begin
                if (flush && !t_wr) t_kill = 1;
                if (!t_acc) begin
                    if (mem_if.mem_req_ready) t_acc = 1;
                end else if (mem_if.mem_resp_valid) begin
                    if (t_wr) n_ack = 1;
                    else if (!t_kill) begin
                        n_succ = 1;
                        e_stag = t_tag;
                        e_data = mem_if.mem_resp_rdata;
                    end
                    t_act = 0;
                end
            end else begin
                idx = oldest();
                if (stq_commit_valid && (starve == SL || idx < 0)) begin
                    t_act = 1; t_acc = 0; t_wr = 1; t_kill = 0;
                    t_addr = stq_commit_addr; t_wdata = stq_commit_data; t_tag = 0;
                    starve = 0;
                end else if (idx >= 0) begin
                    t_act = 1; t_acc = 0; t_wr = 0; t_kill = flush; t_idx = idx;
                    t_addr = e_addr[idx]; t_wdata = 0; t_tag = e_tag[idx];
                    starve = stq_commit_valid ? ((starve < SL) ? starve + 1 : SL) : 0;
                end else if (!stq_commit_valid) begin
                    starve = 0;
                end
            end
            e_succ = n_succ;
            e_ack  = n_ack;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_ldq();
        ldq_valid = '0; ldq_address_valid = '0; ldq_executed = '0;
    endtask

    task automatic set_entry(input int i, input logic [31:0] a, input logic [31:0] t);
        e_addr[i] = a; e_tag[i] = t;
        ldq_valid[i] = 1'b1; ldq_address_valid[i] = 1'b1; ldq_executed[i] = 1'b0;
    endtask

    task automatic wait_exec(input string nm, output logic [31:0] tag);
        bit ok = 0;
        tag = '0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            if (load_executed) begin ok = 1; tag = load_executed_rob_tag; end
        end
        if (!ok) chk({nm, "_exec_timeout"}, 0, 1);
    endtask

    task automatic wait_succ(input string nm, output logic [31:0] tag, output logic [31:0] dat, output int steps);
        bit ok = 0;
        tag = '0; dat = '0; steps = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            steps++;
            if (load_succeeded) begin ok = 1; tag = load_succeeded_rob_tag; dat = load_data; end
        end
        if (!ok) chk({nm, "_succ_timeout"}, 0, 1);
    endtask

    task automatic wait_ack(input string nm);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            if (stq_commit_ack) ok = 1;
        end
        if (!ok) chk({nm, "_ack_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tg, dt;
        int st, cnt, nl;
        bit seen;

        reset = 1'b1; flush = 0; ldq_head = 0;
        stq_commit_valid = 0; stq_commit_addr = 0; stq_commit_data = 0;
        for (int i = 0; i < NQ; i++) begin e_addr[i] = 0; e_tag[i] = 0; end
        clear_ldq();
        mem_if.mem_req_ready = 0; mem_if.mem_resp_valid = 0; mem_if.mem_resp_rdata = 0;
        repeat (3) step();
        chk("reset_valid", mem_if.mem_req_valid, 0);
        chk("reset_succ", load_succeeded, 0);
        reset = 1'b0;
        repeat (3) step();
        chk("idle_valid", mem_if.mem_req_valid, 0);

        // single load
        set_entry(0, 32'd42, 32'd19);
        wait_exec("single", tg);
        chk("single_exec_tag", tg, 32'd19);
        chk("single_addr", mem_if.mem_req_addr, 32'd42);
        chk("single_write", mem_if.mem_req_write, 0);
        wait_succ("single", tg, dt, st);
        chk("single_succ_tag", tg, 32'd19);
        chk("single_data", dt, 32'h0000DEAD);
        chk("single_latency", st, 2);
        clear_ldq();
        repeat (3) step();

        // age order with wrap
        ldq_head = 4'd14;
        set_entry(15, 32'h200, 32'd7);
        set_entry(1, 32'h300, 32'd3);
        wait_exec("wrap1", tg);
        chk("wrap_first_tag", tg, 32'd7);
        wait_exec("wrap2", tg);
        chk("wrap_second_tag", tg, 32'd3);
        repeat (4) step();
        clear_ldq();
        ldq_head = 0;

        // ready backpressure
        rdy_delay = 3;
        set_entry(2, 32'h44, 32'd21);
        cnt = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (mem_if.mem_req_valid) cnt++;
            if (load_executed) begin seen = 1; tg = load_executed_rob_tag; end
        end
        chk("bp_valid_cycles", cnt, 4);
        chk("bp_exec_tag", tg, 32'd21);
        rdy_delay = 0;
        wait_succ("bp", tg, dt, st);
        chk("bp_succ_tag", tg, 32'd21);
        clear_ldq();
        repeat (3) step();

        // starvation
        for (int i = 0; i < 10; i++) set_entry(i, 32'h1000 + 32'(4*i), 32'(40 + i));
        stq_commit_valid = 1; stq_commit_addr = 32'h100; stq_commit_data = 32'd5;
        for (int round = 0; round < 2; round++) begin
            nl = 0; seen = 0;
            for (int k = 0; k < 60 && !seen; k++) begin
                step();
                if (load_executed) nl++;
                if (mem_if.mem_req_valid && mem_if.mem_req_write) seen = 1;
            end
            chk("starve_loads", nl, 4);
            chk("starve_wdata", mem_if.mem_req_wdata, round == 0 ? 32'd5 : 32'd6);
            chk("starve_addr", mem_if.mem_req_addr, round == 0 ? 32'h100 : 32'h104);
            wait_ack("starve");
            if (round == 0) begin
                stq_commit_addr = 32'h104; stq_commit_data = 32'd6;
            end else begin
                stq_commit_valid = 0;
            end
        end
        repeat (12) step();
        clear_ldq();
        repeat (2) step();

        // flush while the load waits in RESP
        resp_delay = 2;
        ldq_head = 4'd3;
        set_entry(3, 32'h500, 32'd9);
        set_entry(4, 32'h504, 32'd11);
        wait_exec("flresp", tg);
        chk("flresp_exec_tag", tg, 32'd9);
        step();
        flush = 1;
        step();
        flush = 0;
        seen = 0; cnt = 0; nl = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (load_succeeded && load_succeeded_rob_tag == 32'd9) seen = 1;
            if (load_executed && load_executed_rob_tag == 32'd11) nl++;
            if (load_succeeded && load_succeeded_rob_tag == 32'd11) cnt++;
        end
        chk("flresp_no_succ9", seen, 0);
        chk("flresp_next_exec", nl, 1);
        chk("flresp_next_succ", cnt, 1);
        resp_delay = 0;
        clear_ldq();
        ldq_head = 0;

        // flush in the response cycle
        set_entry(5, 32'h600, 32'd13);
        wait_exec("flsame", tg);
        step();
        flush = 1;
        step();
        flush = 0;
        chk("flsame_no_succ", load_succeeded, 0);
        repeat (3) step();
        clear_ldq();

        // flush in the acceptance cycle
        rdy_delay = 2;
        set_entry(6, 32'h700, 32'd15);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (load_executed) begin seen = 1; flush = 1; end
        end
        chk("flacc_exec_seen", seen, 1);
        step();
        flush = 0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (load_succeeded) cnt++;
        end
        chk("flacc_no_succ", cnt, 0);
        rdy_delay = 0;
        clear_ldq();

        // stray response while idle
        step();
        stray = 1;
        step();
        step();
        stray = 0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (load_succeeded || stq_commit_ack) cnt++;
        end
        chk("stray_no_pulse", cnt, 0);

        // asynchronous reset while in REQ
        rdy_delay = 100;
        set_entry(7, 32'h800, 32'd17);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (mem_if.mem_req_valid) seen = 1;
        end
        chk("rstreq_valid_seen", seen, 1);
        #1 reset = 1;
        #1;
        chk("rstreq_valid", mem_if.mem_req_valid, 0);
        chk("rstreq_addr", mem_if.mem_req_addr, 0);
        chk("rstreq_exec", load_executed, 0);
        step();
        clear_ldq();
        rdy_delay = 0;
        step();
        reset = 0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (mem_if.mem_req_valid || load_executed || load_succeeded || stq_commit_ack) cnt++;
        end
        chk("rstreq_quiet", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
